// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction-memory handshake and fills the IF/ID register.
// A one-entry buffer absorbs a response that arrives while decode is stalled.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic [4:0]  ifid_opcode
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_stale_addr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_inst;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_inst;

    logic [31:0] w_redirect_target;
    logic [31:0] w_pc_inc;

    assign w_redirect_target = redirect_pc & ~32'h0000_0003;
    assign w_pc_inc          = r_pc + 32'd4;

    // Request is gated by rst_n so it rises in the very cycle reset is released.
    assign imem_req    = rst_n && (r_state != HOLD);
    assign imem_addr   = (r_state == DROP) ? r_stale_addr : r_pc;

    assign ifid_valid  = r_ifid_valid;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_inst   = r_ifid_inst;
    assign ifid_opcode = r_ifid_inst[6:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_stale_addr <= 32'd0;
            r_buf_pc     <= 32'd0;
            r_buf_inst   <= NOP;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_inst  <= NOP;
        end else if (redirect) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_inst  <= NOP;
            r_buf_pc     <= 32'd0;
            r_buf_inst   <= NOP;
            r_pc         <= w_redirect_target;
            // An unanswered request must still be drained; keep presenting its address.
            if ((r_state != HOLD) && !imem_ready) begin
                r_state <= DROP;
                if (r_state == FETCH) begin
                    r_stale_addr <= r_pc;
                end
            end else begin
                r_state <= FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        r_pc <= w_pc_inc;
                        if (stall) begin
                            r_buf_pc   <= r_pc;
                            r_buf_inst <= imem_rdata;
                            r_state    <= HOLD;
                        end else begin
                            r_ifid_valid <= 1'b1;
                            r_ifid_pc    <= r_pc;
                            r_ifid_inst  <= imem_rdata;
                        end
                    end else if (!stall) begin
                        r_ifid_valid <= 1'b0;
                        r_ifid_pc    <= 32'd0;
                        r_ifid_inst  <= NOP;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_ifid_valid <= 1'b1;
                        r_ifid_pc    <= r_buf_pc;
                        r_ifid_inst  <= r_buf_inst;
                        r_buf_pc     <= 32'd0;
                        r_buf_inst   <= NOP;
                        r_state      <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus a randomized run against a transaction-level model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic [4:0]  ifid_opcode;

    int n_checks = 0;
    int n_pass   = 0;

    inst_fetch #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
        .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_opcode(ifid_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program counter, a queue standing for the stall buffer,
    // and a pending-discard flag with the address still owed a response.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_buf[$];
    logic [31:0] m_pc      = RESET_PC;
    logic        m_discard = 1'b0;
    logic [31:0] m_stale   = 32'd0;
    logic        m_v       = 1'b0;
    logic [31:0] m_ipc     = 32'd0;
    logic [31:0] m_inst    = NOP;

    function automatic logic m_req();
        return rst_n && (m_buf.size() == 0);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_discard ? m_stale : m_pc;
    endfunction

    // Applies inputs from a falling edge, advances one rising edge, returns at the next falling edge.
    task automatic drive(input bit rn, input bit st, input bit rd, input logic [31:0] rpc,
                         input bit rdy, input logic [31:0] rdata);
        bit   req_now;
        bit   acc;
        ent_t e;
        rst_n       = rn;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        req_now     = m_req();
        acc         = rdy && req_now;
        imem_ready  = acc;
        imem_rdata  = rdata;
        @(posedge clk);
        if (!rn) begin
            m_pc = RESET_PC; m_discard = 0; m_buf.delete();
            m_v = 0; m_ipc = 0; m_inst = NOP;
        end else if (rd) begin
            m_v = 0; m_ipc = 0; m_inst = NOP; m_buf.delete();
            if (req_now && !acc) begin
                if (!m_discard) m_stale = m_pc;
                m_discard = 1;
            end else begin
                m_discard = 0;
            end
            m_pc = {rpc[31:2], 2'b00};
        end else if (m_buf.size() != 0) begin
            if (!st) begin
                m_v = 1; m_ipc = m_buf[0].pc; m_inst = m_buf[0].inst; m_buf.delete();
            end
        end else if (m_discard) begin
            if (acc) m_discard = 0;
        end else if (acc) begin
            if (st) begin
                e.pc = m_pc; e.inst = rdata; m_buf.push_back(e);
            end else begin
                m_v = 1; m_ipc = m_pc; m_inst = rdata;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_v = 0; m_ipc = 0; m_inst = NOP;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", imem_req); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", ifid_valid); else n_pass++;
        n_checks++; if (ifid_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", ifid_pc); else n_pass++;
        n_checks++; if (ifid_inst !== NOP) $display("FAIL reset_inst got %h want %h", ifid_inst, NOP); else n_pass++;
        n_checks++; if (ifid_opcode !== 5'b00100) $display("FAIL reset_opcode got %b want 00100", ifid_opcode); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL release_req got %0b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL release_addr got %h want %h", imem_addr, RESET_PC); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] d;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            drive(1, 0, 0, 0, 1, d);
            n_checks++; if (ifid_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %0b want 1", k, ifid_valid); else n_pass++;
            n_checks++; if (ifid_pc !== 32'(4 * k)) $display("FAIL seq_pc[%0d] got %h want %h", k, ifid_pc, 32'(4 * k)); else n_pass++;
            n_checks++; if (ifid_inst !== d) $display("FAIL seq_inst[%0d] got %h want %h", k, ifid_inst, d); else n_pass++;
            n_checks++; if (ifid_opcode !== d[6:2]) $display("FAIL seq_opcode[%0d] got %b want %b", k, ifid_opcode, d[6:2]); else n_pass++;
            n_checks++; if (imem_addr !== 32'(4 * k + 4)) $display("FAIL seq_addr[%0d] got %h want %h", k, imem_addr, 32'(4 * k + 4)); else n_pass++;
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1, 0, 0, 0, 1, $urandom);
        drive(1, 0, 0, 0, 1, $urandom);
        drive(1, 1, 0, 0, 1, 32'h0000_0033);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (imem_req !== 1'b0) $display("FAIL hold_req[%0d] got %0b want 0", k, imem_req); else n_pass++;
            n_checks++; if (ifid_pc !== 32'd4) $display("FAIL hold_pc[%0d] got %h want 4", k, ifid_pc); else n_pass++;
            if (k < 2) drive(1, 1, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 0, 0, 0);
        n_checks++; if (ifid_pc !== 32'd8) $display("FAIL unhold_pc got %h want 8", ifid_pc); else n_pass++;
        n_checks++; if (ifid_inst !== 32'h33) $display("FAIL unhold_inst got %h want 33", ifid_inst); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b1) $display("FAIL unhold_valid got %0b want 1", ifid_valid); else n_pass++;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL unhold_req got %0b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'd12) $display("FAIL unhold_addr got %h want c", imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        for (int k = 0; k < 8; k++) drive(1, 0, 0, 0, 1, $urandom);
        drive(1, 0, 1, 32'h100, 0, 0);
        n_checks++; if (imem_addr !== 32'h20) $display("FAIL drop_addr0 got %h want 20", imem_addr); else n_pass++;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL drop_req got %0b want 1", imem_req); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL drop_valid0 got %0b want 0", ifid_valid); else n_pass++;
        drive(1, 0, 0, 0, 0, 0);
        n_checks++; if (imem_addr !== 32'h20) $display("FAIL drop_addr1 got %h want 20", imem_addr); else n_pass++;
        drive(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        n_checks++; if (imem_addr !== 32'h100) $display("FAIL drop_target got %h want 100", imem_addr); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL drop_valid1 got %0b want 0", ifid_valid); else n_pass++;
        drive(1, 0, 0, 0, 1, 32'h1234_5678);
        n_checks++; if (ifid_pc !== 32'h100) $display("FAIL after_drop_pc got %h want 100", ifid_pc); else n_pass++;
        n_checks++; if (ifid_inst !== 32'h1234_5678) $display("FAIL after_drop_inst got %h want 12345678", ifid_inst); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        drive(1, 1, 1, 32'h203, 1, $urandom);
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL rs_valid got %0b want 0", ifid_valid); else n_pass++;
        n_checks++; if (ifid_inst !== NOP) $display("FAIL rs_inst got %h want %h", ifid_inst, NOP); else n_pass++;
        n_checks++; if (ifid_pc !== 32'd0) $display("FAIL rs_pc got %h want 0", ifid_pc); else n_pass++;
        n_checks++; if (imem_addr !== 32'h200) $display("FAIL rs_addr got %h want 200", imem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        drive(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        drive(1, 0, 0, 0, 1, $urandom);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got %h want fffffffc", imem_addr); else n_pass++;
        drive(1, 0, 0, 0, 1, $urandom);
        n_checks++; if (ifid_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffc", ifid_pc); else n_pass++;
        n_checks++; if (imem_addr !== 32'd0) $display("FAIL wrap_addr1 got %h want 0", imem_addr); else n_pass++;
    endtask

    task automatic test_reset_in_drop();
        drive(1, 0, 0, 0, 1, $urandom);
        drive(1, 0, 1, 32'h400, 0, 0);
        n_checks++; if (imem_addr !== 32'd4) $display("FAIL rd_stale got %h want 4", imem_addr); else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rd_req got %0b want 0", imem_req); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL rd_valid got %0b want 0", ifid_valid); else n_pass++;
        drive(1, 0, 0, 0, 0, 0);
        n_checks++; if (imem_req !== 1'b1) $display("FAIL rd_rel_req got %0b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL rd_rel_addr got %h want %h", imem_addr, RESET_PC); else n_pass++;
    endtask

    task automatic test_random();
        bit rn, st, rd, rdy;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rn  = ($urandom_range(0, 99) >= 2);
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 60);
            drive(rn, st, rd, $urandom, rdy, $urandom);
            n_checks++; if (imem_req !== m_req()) $display("FAIL rnd_req[%0d] got %0b want %0b", k, imem_req, m_req()); else n_pass++;
            if (m_req()) begin
                n_checks++; if (imem_addr !== m_addr()) $display("FAIL rnd_addr[%0d] got %h want %h", k, imem_addr, m_addr()); else n_pass++;
            end
            n_checks++; if (ifid_valid !== m_v) $display("FAIL rnd_valid[%0d] got %0b want %0b", k, ifid_valid, m_v); else n_pass++;
            n_checks++; if (ifid_pc !== m_ipc) $display("FAIL rnd_pc[%0d] got %h want %h", k, ifid_pc, m_ipc); else n_pass++;
            n_checks++; if (ifid_inst !== m_inst) $display("FAIL rnd_inst[%0d] got %h want %h", k, ifid_inst, m_inst); else n_pass++;
            n_checks++; if (ifid_opcode !== m_inst[6:2]) $display("FAIL rnd_opcode[%0d] got %b want %b", k, ifid_opcode, m_inst[6:2]); else n_pass++;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'd0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
        test_reset_in_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
